// File: rtl/tio_clock_freq_mon_if.sv
// WISHBONE target bus for the clock frequency monitor.
// Signal names keep the target-side _i/_o suffixes so they line up with the register bank.
interface tio_clock_freq_mon_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [9:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/tio_clock_freq_mon.sv
// Multi-channel clock frequency monitor: counts synchronised toggle edges per gate interval,
// checks each count against a window and raises maskable sticky alarms via a WISHBONE target.
module tio_clock_freq_mon #(
    parameter int                NUM_CLOCKS   = 8,
    parameter int                COUNT_W      = 16,
    parameter int                GATE_W       = 24,
    parameter logic [GATE_W-1:0] DEFAULT_GATE = 24'd1000000,
    parameter logic [15:0]       RUN_MIN      = 16'd2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    tio_clock_freq_mon_if.slave   wb,
    input  logic [NUM_CLOCKS-1:0] clk_tog_i,
    output logic [NUM_CLOCKS-1:0] clk_running_o,
    output logic                  alarm_o
);

    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [GATE_W-1:0]  GATE_MIN = GATE_W'(4);
    localparam logic [GATE_W-1:0]  GATE_ONE = GATE_W'(1);
    localparam logic [31:0]        WIN_RST  = 32'hFFFF_0000;

    localparam logic [7:0] W_GATE   = 8'h80;
    localparam logic [7:0] W_STICKY = 8'h81;
    localparam logic [7:0] W_STATUS = 8'h82;
    localparam logic [7:0] W_MASK   = 8'h83;

    logic [NUM_CLOCKS-1:0] tog_s1;
    logic [NUM_CLOCKS-1:0] tog_s2;
    logic [NUM_CLOCKS-1:0] tog_prev;
    logic [NUM_CLOCKS-1:0] tog_edge;

    logic [COUNT_W-1:0] acc_q     [NUM_CLOCKS];
    logic [COUNT_W-1:0] count_q   [NUM_CLOCKS];
    logic [COUNT_W-1:0] latch_val [NUM_CLOCKS];
    logic [31:0]        win_q     [NUM_CLOCKS];

    logic [NUM_CLOCKS-1:0] running_q;
    logic [NUM_CLOCKS-1:0] run_now;
    logic [NUM_CLOCKS-1:0] win_bad;
    logic [NUM_CLOCKS-1:0] sticky_q;
    logic [NUM_CLOCKS-1:0] sticky_set;
    logic [NUM_CLOCKS-1:0] sticky_clr;
    logic [NUM_CLOCKS-1:0] mask_q;
    logic                  valid_q;

    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [GATE_W-1:0] gate_new;
    logic              terminal;

    logic                  ack_q;
    logic [7:0]            word;
    logic                  wr_en;
    logic                  wr_gate;
    logic                  wr_sticky;
    logic                  wr_mask;
    logic [NUM_CLOCKS-1:0] wr_win;
    logic [31:0]           gate_ext;
    logic [31:0]           gate_merged;
    logic [31:0]           mask_ext;
    logic [31:0]           mask_merged;
    logic [31:0]           clr_merged;
    logic [31:0]           rd_data;
    logic                  unused_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Two-stage synchroniser plus a history register; any change of the synced level is an edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tog_s1   <= '0;
            tog_s2   <= '0;
            tog_prev <= '0;
        end else begin
            tog_s1   <= clk_tog_i;
            tog_s2   <= tog_s1;
            tog_prev <= tog_s2;
        end
    end

    assign tog_edge = tog_s2 ^ tog_prev;

    // Bus decode; writes land in the cycle the ack is visible.
    assign word      = wb.wb_adr_i[9:2];
    assign wr_en     = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i & ack_q;
    assign wr_gate   = wr_en && (word == W_GATE);
    assign wr_sticky = wr_en && (word == W_STICKY);
    assign wr_mask   = wr_en && (word == W_MASK);

    always_comb begin
        wr_win = '0;
        for (int n = 0; n < NUM_CLOCKS; n++) begin
            wr_win[n] = wr_en && (word[7:6] == 2'b01) && (word[5:0] == 6'(n));
        end
    end

    always_comb begin
        gate_ext                 = '0;
        gate_ext[GATE_W-1:0]     = gate_q;
        mask_ext                 = '0;
        mask_ext[NUM_CLOCKS-1:0] = mask_q;
        gate_merged = byte_merge(gate_ext, wb.wb_dat_i, wb.wb_sel_i);
        mask_merged = byte_merge(mask_ext, wb.wb_dat_i, wb.wb_sel_i);
        clr_merged  = byte_merge(32'h0, wb.wb_dat_i, wb.wb_sel_i);
        gate_new    = (gate_merged[GATE_W-1:0] < GATE_MIN) ? GATE_MIN : gate_merged[GATE_W-1:0];
        sticky_clr  = wr_sticky ? clr_merged[NUM_CLOCKS-1:0] : '0;
    end

    assign terminal = (gate_cnt_q == '0);

    // Per-channel value that would be latched this cycle, and its window/running verdicts.
    always_comb begin
        logic [15:0] lv16;
        for (int n = 0; n < NUM_CLOCKS; n++) begin
            latch_val[n] = acc_q[n];
            if (tog_edge[n] && (acc_q[n] != CNT_MAX)) begin
                latch_val[n] = acc_q[n] + CNT_ONE;
            end
            lv16                = '0;
            lv16[COUNT_W-1:0]   = latch_val[n];
            win_bad[n]          = (lv16 < win_q[n][15:0]) || (lv16 > win_q[n][31:16]);
            run_now[n]          = (lv16 >= RUN_MIN);
        end
    end

    // A gate write discards the current interval, so it also blocks any alarm this cycle.
    assign sticky_set = (terminal && valid_q && !wr_gate) ? win_bad : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            gate_q     <= DEFAULT_GATE;
            gate_cnt_q <= DEFAULT_GATE - GATE_ONE;
            valid_q    <= 1'b0;
        end else if (wr_gate) begin
            gate_q     <= gate_new;
            gate_cnt_q <= gate_new - GATE_ONE;
            valid_q    <= 1'b0;
        end else if (terminal) begin
            gate_cnt_q <= gate_q - GATE_ONE;
            valid_q    <= 1'b1;
        end else begin
            gate_cnt_q <= gate_cnt_q - GATE_ONE;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            running_q <= '0;
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                acc_q[n]   <= '0;
                count_q[n] <= '0;
                win_q[n]   <= WIN_RST;
            end
        end else begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                if (wr_gate) begin
                    acc_q[n] <= '0;
                end else if (terminal) begin
                    acc_q[n]     <= '0;
                    count_q[n]   <= latch_val[n];
                    running_q[n] <= run_now[n];
                end else begin
                    acc_q[n] <= latch_val[n];
                end
                if (wr_win[n]) begin
                    win_q[n] <= byte_merge(win_q[n], wb.wb_dat_i, wb.wb_sel_i);
                end
            end
        end
    end

    // Set beats clear when both hit the same bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sticky_q <= '0;
            mask_q   <= '0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
            if (wr_mask) begin
                mask_q <= mask_merged[NUM_CLOCKS-1:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if (word[7:6] == 2'b00) begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                if (word[5:0] == 6'(n)) rd_data[COUNT_W-1:0] = count_q[n];
            end
        end else if (word[7:6] == 2'b01) begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                if (word[5:0] == 6'(n)) rd_data = win_q[n];
            end
        end else begin
            case (word)
                W_GATE:   rd_data[GATE_W-1:0]     = gate_q;
                W_STICKY: rd_data[NUM_CLOCKS-1:0] = sticky_q;
                W_STATUS: begin
                    rd_data[NUM_CLOCKS-1:0] = running_q;
                    rd_data[31]             = valid_q;
                end
                W_MASK:   rd_data[NUM_CLOCKS-1:0] = mask_q;
                default:  rd_data = '0;
            endcase
        end
    end

    assign wb.wb_dat_o   = rd_data;
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_err_o   = 1'b0;
    assign wb.wb_rty_o   = 1'b0;
    assign clk_running_o = running_q;
    assign alarm_o       = |(sticky_q & mask_q);

    assign unused_bits = ^{wb.wb_adr_i[1:0], gate_merged, mask_merged, clr_merged};

endmodule

// File: tb/tb_tio_clock_freq_mon.sv
// Scoreboard bench for tio_clock_freq_mon: expected register values are queued as stimulus
// is applied and popped when the matching bus read returns.
module tb_tio_clock_freq_mon;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tog = '0;
    logic [7:0] running;
    logic       alarm;

    tio_clock_freq_mon_if bus();

    tio_clock_freq_mon #(
        .NUM_CLOCKS(8), .COUNT_W(16), .GATE_W(24),
        .DEFAULT_GATE(24'd1000000), .RUN_MIN(16'd2)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb(bus),
        .clk_tog_i(tog),
        .clk_running_o(running),
        .alarm_o(alarm)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_cnt = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned shot_a = 32'hFFFF_FFFF;
    int unsigned shot_b = 32'hFFFF_FFFF;
    int          tog_period [8] = '{default: 0};
    int          tog_cnt    [8] = '{default: 0};
    logic [31:0] exp_q [$];
    logic [31:0] rd;
    logic [31:0] e;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Toggle sources: periodic per channel, plus two one-shot toggles on ch0 at chosen cycles.
    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) begin
            if (tog_period[c] != 0) begin
                if (tog_cnt[c] >= tog_period[c] - 1) begin
                    tog[c]     = ~tog[c];
                    tog_cnt[c] = 0;
                end else begin
                    tog_cnt[c]++;
                end
            end
        end
        if (cyc_cnt == shot_a || cyc_cnt == shot_b) tog[0] = ~tog[0];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wb_ack_o !== 1'b1 && n < 16);
        if (bus.wb_ack_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wb_ack timeout: adr %h, ack %b after %0d cycles, want 1", adr, bus.wb_ack_o, n);
        end
        rdata = bus.wb_dat_o;
        @(posedge clk);
        #1;
        last_wr_cyc  = cyc_cnt;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [9:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, dat, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [9:0] adr, output logic [31:0] rdata);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rdata);
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc_cnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.wb_ack_o !== 1'b0 || alarm !== 1'b0 || running !== 8'h00) begin
            errors++;
            $display("FAIL reset outputs: ack %b alarm %b running %h, want 0 0 00", bus.wb_ack_o, alarm, running);
        end
        exp_q.push_back(32'h0);          // count0
        exp_q.push_back(32'd1000000);    // gate
        exp_q.push_back(32'h0);          // status
        exp_q.push_back(32'hFFFF_0000);  // window0
        exp_q.push_back(32'h0);          // mask
        exp_q.push_back(32'h0);          // sticky
        foreach (exp_q[i]) begin end
        begin
            logic [9:0] addrs [6] = '{10'h000, 10'h200, 10'h208, 10'h100, 10'h20C, 10'h204};
            for (int i = 0; i < 6; i++) begin
                wb_read(addrs[i], rd);
                e = exp_q.pop_front();
                checks++;
                if (rd !== e) begin
                    errors++;
                    $display("FAIL reset reg %h: got %h want %h", addrs[i], rd, e);
                end
            end
        end
    endtask

    task automatic test_unmapped_sel;
        logic [31:0] d;
        wb_xfer(1'b1, 10'h10C, 32'hAABB_CCDD, 4'b0101, d);
        exp_q.push_back(32'hFFBB_00DD);
        wb_read(10'h10C, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL byte_sel window3: got %h want %h", rd, e); end
        wb_write(10'h120, 32'h1234_5678);
        exp_q.push_back(32'h0);
        wb_read(10'h120, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL unmapped window8: got %h want %h", rd, e); end
        exp_q.push_back(32'h0);
        wb_read(10'h3FC, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL unmapped 3FC: got %h want %h", rd, e); end
        wb_write(10'h10C, 32'hFFFF_0000);
    endtask

    task automatic test_count_basic;
        int unsigned w;
        tog_period[0] = 5;
        repeat (10) @(negedge clk);
        wb_write(10'h200, 32'd1000);
        w = last_wr_cyc;
        wait_cyc(w + 1000);
        exp_q.push_back(32'd200);
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 first interval: got %0d want %0d", rd, e); end
        wait_cyc(w + 2000);
        exp_q.push_back(32'd200);
        exp_q.push_back(32'h8000_0001);
        exp_q.push_back(32'd0);
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 second interval: got %0d want %0d", rd, e); end
        wb_read(10'h208, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL status after ch0: got %h want %h", rd, e); end
        wb_read(10'h004, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count1 static: got %0d want %0d", rd, e); end
        checks++;
        if (running !== 8'h01) begin errors++; $display("FAIL clk_running_o: got %h want 01", running); end
    endtask

    task automatic test_window_alarm(output int unsigned w2);
        wb_write(10'h104, 32'hFFFF_000A);
        wb_write(10'h20C, 32'h0000_0002);
        wb_write(10'h200, 32'd1000);
        w2 = last_wr_cyc;
        wait_cyc(w2 + 1000);
        exp_q.push_back(32'h0);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky after first interval: got %h want %h", rd, e); end
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm after first interval: got %b want 0", alarm); end
        wait_cyc(w2 + 2000);
        exp_q.push_back(32'h2);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky after second interval: got %h want %h", rd, e); end
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL alarm after second interval: got %b want 1", alarm); end
    endtask

    task automatic test_clear_vs_set(input int unsigned w2);
        int unsigned t3;
        t3 = w2 + 3000;
        wait_cyc(t3 - 2);
        wb_write(10'h204, 32'h2);
        checks++;
        if (last_wr_cyc != t3) begin errors++; $display("FAIL clear timing: write at cycle %0d want %0d", last_wr_cyc, t3); end
        exp_q.push_back(32'h2);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky set beats clear: got %h want %h", rd, e); end
        wb_write(10'h104, 32'hFFFF_0000);
        wb_write(10'h204, 32'h2);
        exp_q.push_back(32'h0);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky cleared: got %h want %h", rd, e); end
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm after clear: got %b want 0", alarm); end
        wait_cyc(t3 + 1000);
        exp_q.push_back(32'h0);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky stays clear: got %h want %h", rd, e); end
    endtask

    task automatic test_saturate;
        int unsigned w;
        tog_period[2] = 1;
        repeat (4) @(negedge clk);
        wb_write(10'h200, 32'd65540);
        w = last_wr_cyc;
        wait_cyc(w + 65540);
        exp_q.push_back(32'h0000_FFFF);
        exp_q.push_back(32'd13108);
        exp_q.push_back(32'h8000_0005);
        wb_read(10'h008, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count2 saturation: got %h want %h", rd, e); end
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 long gate: got %0d want %0d", rd, e); end
        wb_read(10'h208, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL status long gate: got %h want %h", rd, e); end
    endtask

    task automatic test_min_gate;
        int unsigned w;
        int unsigned t;
        tog_period[0] = 0;
        tog_period[2] = 0;
        wb_write(10'h100, 32'hFFFF_FFFF);
        wb_write(10'h20C, 32'h0000_0001);
        wb_write(10'h204, 32'h0000_00FF);
        wb_write(10'h200, 32'd2);
        w = last_wr_cyc;
        t = w + 8;
        shot_a = t - 5;
        shot_b = t - 3;
        wait_cyc(w + 4);
        exp_q.push_back(32'h0);
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky first short interval: got %h want %h", rd, e); end
        wait_cyc(t);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'h8000_0001);
        exp_q.push_back(32'h1);
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 terminal edge: got %0d want %0d", rd, e); end
        wb_read(10'h208, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL status run_min: got %h want %h", rd, e); end
        wb_read(10'h204, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL sticky second short interval: got %h want %h", rd, e); end
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL alarm short gate: got %b want 1", alarm); end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 next interval: got %0d want %0d", rd, e); end
        wb_read(10'h200, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL gate clamp: got %0d want %0d", rd, e); end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 10'h200;
        @(posedge clk);
        #1;
        checks++;
        if (bus.wb_ack_o !== 1'b1) begin errors++; $display("FAIL ack before reset: got %b want 1", bus.wb_ack_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack on async reset: got %b want 0", bus.wb_ack_o); end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'd1000000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_0000);
        wb_read(10'h200, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL gate after reset: got %0d want %0d", rd, e); end
        wb_read(10'h000, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count0 after reset: got %0d want %0d", rd, e); end
        wb_read(10'h100, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL window0 after reset: got %h want %h", rd, e); end
        checks++;
        if (alarm !== 1'b0 || running !== 8'h00) begin
            errors++;
            $display("FAIL outputs after reset: alarm %b running %h want 0 00", alarm, running);
        end
    endtask

    initial begin
        int unsigned w2;
        test_reset();
        test_unmapped_sel();
        test_count_basic();
        test_window_alarm(w2);
        test_clear_vs_set(w2);
        test_saturate();
        test_min_gate();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
